// File: rtl/emif_ram_arbiter_pkg.sv
// emif_pkg: shared widths and state/source encodings for the EMIF RAM arbiter
package emif_pkg;
  localparam int EMIF_ADDR_W = 7;
  localparam int EMIF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} arb_state_t;
  typedef enum logic {SRC_HOST, SRC_INT} src_t;
endpackage

// File: rtl/emif_ram_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin picker; the pointer moves past the winner on upd
// Ports: clk, rst (async, active-high), req (request levels), upd (grant strobe),
//        any (some request set), idx (winner index), gnt (one-hot winner)
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  output logic             any,
  output logic [IW-1:0]    idx,
  output logic [N_REQ-1:0] gnt
);
  logic [IW-1:0] ptr_q, ptr_d, k;
  always_comb begin
    any = 1'b0;
    idx = '0;
    k = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = IW'((int'(ptr_q) + i) % N_REQ);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end
  assign gnt = any ? N_REQ'(1) << idx : '0;
  assign ptr_d = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else if (upd) ptr_q <= ptr_d;
endmodule

// File: rtl/emif_ram_arbiter.sv
// emif_ram_arbiter: sequences host (priority) and round-robin internal accesses to one RAM port
// Ports: clk, rst (async, active-high); emif_* host port with ack pulse and wait flag;
//        int_* packed internal requesters with gnt/rvalid pulses; ram_* RAM strobes and data.
// Optional: define EMIF_ARB_FAIRNESS_EN to force an internal grant after HOST_STREAK host grants.
module emif_ram_arbiter
  import emif_pkg::*;
#(
  parameter int ADDR_W = EMIF_ADDR_W,
  parameter int DATA_W = EMIF_DATA_W,
  parameter int N_REQ = 2,
  parameter int HOST_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    emif_req,
  input  logic                    emif_we,
  input  logic [ADDR_W-1:0]       emif_addr,
  input  logic [DATA_W-1:0]       emif_wdata,
  output logic [DATA_W-1:0]       emif_rdata,
  output logic                    emif_ack,
  output logic                    emif_wait,
  input  logic [N_REQ-1:0]        int_req,
  input  logic [N_REQ-1:0]        int_we,
  input  logic [N_REQ*ADDR_W-1:0] int_addr,
  input  logic [N_REQ*DATA_W-1:0] int_wdata,
  output logic [N_REQ-1:0]        int_gnt,
  output logic [N_REQ-1:0]        int_rvalid,
  output logic [DATA_W-1:0]       int_rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  arb_state_t state_q, state_d;
  src_t src_q;
  logic we_q, rearm_q, rearm_d, idle, issue, capture, resp;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, emif_rdata_q, int_rdata_q;
  logic [N_REQ-1:0] win_q, int_oh;
  logic [IW-1:0] int_idx;
  logic int_any, host_win, int_win, force_int;
  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .clk(clk), .rst(rst), .req(int_req), .upd(int_win),
    .any(int_any), .idx(int_idx), .gnt(int_oh)
  );
`ifdef EMIF_ARB_FAIRNESS_EN
  localparam int SW = $clog2(HOST_STREAK + 1);
  logic [SW-1:0] streak_q, streak_d;
  assign force_int = streak_q == SW'(HOST_STREAK);
  assign streak_d = (!int_any || int_win) ? '0 : host_win ? streak_q + 1'b1 : streak_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) streak_q <= '0;
    else streak_q <= streak_d;
`else
  assign force_int = 1'b0;
`endif
  assign idle = state_q == IDLE;
  assign issue = state_q == ISSUE;
  assign capture = state_q == CAPTURE;
  assign resp = state_q == RESP;
  assign host_win = idle && emif_req && rearm_q && !(force_int && int_any);
  assign int_win = idle && int_any && !host_win;
  assign state_d = idle ? ((host_win || int_win) ? ISSUE : IDLE)
                 : issue ? (we_q ? IDLE : CAPTURE)
                 : capture ? RESP : IDLE;
  // Dropping emif_req in the ack cycle rearms at once; a level held across the ack does not
  assign rearm_d = !emif_req || (rearm_q && !emif_ack);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      src_q <= SRC_HOST;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      win_q <= '0;
      rearm_q <= 1'b1;
      emif_rdata_q <= '0;
      int_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
      if (host_win || int_win) begin
        src_q <= host_win ? SRC_HOST : SRC_INT;
        we_q <= host_win ? emif_we : int_we[int_idx];
        addr_q <= host_win ? emif_addr : int_addr[int_idx*ADDR_W +: ADDR_W];
        wdata_q <= host_win ? emif_wdata : int_wdata[int_idx*DATA_W +: DATA_W];
        win_q <= host_win ? '0 : int_oh;
      end
      if (capture && src_q == SRC_HOST) emif_rdata_q <= ram_rdata;
      if (capture && src_q == SRC_INT) int_rdata_q <= ram_rdata;
    end
  assign ram_en = issue;
  assign ram_we = issue && we_q;
  assign ram_addr = issue ? addr_q : '0;
  assign ram_wdata = issue ? wdata_q : '0;
  assign emif_ack = (src_q == SRC_HOST) && ((issue && we_q) || resp);
  assign emif_wait = emif_req && rearm_q && !emif_ack;
  assign int_gnt = issue ? win_q : '0;
  assign int_rvalid = resp ? win_q : '0;
  assign emif_rdata = emif_rdata_q;
  assign int_rdata = int_rdata_q;
endmodule

// File: tb/tb_emif_ram_arbiter.sv
// tb_emif_ram_arbiter: directed stimulus with a queue-based scoreboard for RAM strobes and responses
module tb_emif_ram_arbiter;
  logic clk = 0, rst = 1;
  logic emif_req = 0, emif_we = 0;
  logic [6:0] emif_addr = 0;
  logic [15:0] emif_wdata = 0, emif_rdata, int_rdata, ram_wdata, ram_rdata = 0;
  logic emif_ack, emif_wait, ram_en, ram_we;
  logic [1:0] int_req = 0, int_we = 0, int_gnt, int_rvalid;
  logic [13:0] int_addr = 0;
  logic [31:0] int_wdata = 0;
  logic [6:0] ram_addr;
  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] mem [128];
  typedef struct {logic ack; logic [1:0] gnt; logic [1:0] rv; logic [15:0] data; bit ck; int cyc;} rsp_t;
  typedef struct {logic we; logic [6:0] addr; logic [15:0] wdata; int cyc;} ram_t;
  rsp_t rq[$];
  ram_t mq[$];
  rsp_t r;
  ram_t m;

  emif_ram_arbiter dut (
    .clk(clk), .rst(rst), .emif_req(emif_req), .emif_we(emif_we), .emif_addr(emif_addr),
    .emif_wdata(emif_wdata), .emif_rdata(emif_rdata), .emif_ack(emif_ack), .emif_wait(emif_wait),
    .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_gnt(int_gnt), .int_rvalid(int_rvalid), .int_rdata(int_rdata), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (emif_ack || int_gnt != 2'b00 || int_rvalid != 2'b00) begin
      if (rq.size() == 0) chk("unexpected_rsp", {emif_ack, int_gnt, int_rvalid}, 0);
      else begin
        r = rq.pop_front();
        chk("rsp_ack", emif_ack, r.ack);
        chk("rsp_gnt", int_gnt, r.gnt);
        chk("rsp_rvalid", int_rvalid, r.rv);
        chk("rsp_cycle", cyc, r.cyc);
        if (r.ck) chk("rsp_data", emif_ack ? emif_rdata : int_rdata, r.data);
      end
    end
    if (ram_en) begin
      if (mq.size() == 0) chk("unexpected_ram_en", {ram_we, ram_addr}, 0);
      else begin
        m = mq.pop_front();
        chk("ram_we", ram_we, m.we);
        chk("ram_addr", ram_addr, m.addr);
        chk("ram_cycle", cyc, m.cyc);
        if (m.we) chk("ram_wdata", ram_wdata, m.wdata);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_ram(logic we, logic [6:0] a, logic [15:0] d, int c);
    mq.push_back('{we, a, d, c});
  endtask

  task automatic exp_rsp(logic ack, logic [1:0] g, logic [1:0] rv, logic [15:0] d, bit ck, int c);
    rq.push_back('{ack, g, rv, d, ck, c});
  endtask

  task automatic host_op(logic we, logic [6:0] a, logic [15:0] d, logic [15:0] exp_d);
    int c;
    c = cyc;
    emif_req = 1; emif_we = we; emif_addr = a; emif_wdata = d;
    #1 chk("wait_on_req", emif_wait, 1);
    exp_ram(we, a, d, c + 1);
    exp_rsp(1, 2'b00, 2'b00, exp_d, !we, we ? c + 1 : c + 3);
    tick(we ? 1 : 3);
    chk("wait_in_ack", emif_wait, 0);
    emif_req = 0;
    tick(2);
  endtask

  initial begin
    int c;
    tick(2);
    chk("rst_ack", emif_ack, 0);
    chk("rst_wait", emif_wait, 0);
    chk("rst_gnt", int_gnt, 0);
    chk("rst_rvalid", int_rvalid, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_emif_rdata", emif_rdata, 0);
    rst = 0;
    tick(1);
    // host write then read back
    host_op(1, 7'h3C, 16'h1234, 16'h0);
    host_op(0, 7'h3C, 16'h0, 16'h1234);
    host_op(1, 7'h10, 16'hAAAA, 16'h0);
    host_op(1, 7'h11, 16'h5555, 16'h0);
    // both internal requesters reading: 0,1,0
    c = cyc;
    int_we = 2'b00; int_addr = {7'h11, 7'h10}; int_req = 2'b11;
    exp_ram(0, 7'h10, 0, c + 1); exp_rsp(0, 2'b01, 2'b00, 0, 0, c + 1); exp_rsp(0, 2'b00, 2'b01, 16'hAAAA, 1, c + 3);
    exp_ram(0, 7'h11, 0, c + 5); exp_rsp(0, 2'b10, 2'b00, 0, 0, c + 5); exp_rsp(0, 2'b00, 2'b10, 16'h5555, 1, c + 7);
    exp_ram(0, 7'h10, 0, c + 9); exp_rsp(0, 2'b01, 2'b00, 0, 0, c + 9); exp_rsp(0, 2'b00, 2'b01, 16'hAAAA, 1, c + 11);
    tick(10);
    int_req = 2'b00;
    tick(3);
    // host and req0 raised together
    c = cyc;
    emif_req = 1; emif_we = 1; emif_addr = 7'h20; emif_wdata = 16'hBEEF;
    int_req = 2'b01; int_we = 2'b01; int_addr = {7'h11, 7'h21}; int_wdata = {16'h0, 16'hCAFE};
    exp_ram(1, 7'h20, 16'hBEEF, c + 1); exp_rsp(1, 2'b00, 2'b00, 0, 0, c + 1);
    exp_ram(1, 7'h21, 16'hCAFE, c + 3); exp_rsp(0, 2'b01, 2'b00, 0, 0, c + 3);
    tick(1);
    emif_req = 0;
    tick(2);
    int_req = 2'b00; int_we = 2'b00;
    tick(2);
    host_op(0, 7'h21, 16'h0, 16'hCAFE);
    // host level held across the ack
    c = cyc;
    emif_req = 1; emif_we = 0; emif_addr = 7'h3C;
    exp_ram(0, 7'h3C, 0, c + 1); exp_rsp(1, 2'b00, 2'b00, 16'h1234, 1, c + 3);
    tick(3);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("held_wait", emif_wait, 0);
    end
    emif_req = 0;
    tick(1);
    host_op(1, 7'h3D, 16'h7777, 16'h0);
    // reset during CAPTURE of an internal read
    c = cyc;
    int_addr = {7'h11, 7'h10}; int_req = 2'b10;
    exp_ram(0, 7'h11, 0, c + 1); exp_rsp(0, 2'b10, 2'b00, 0, 0, c + 1);
    tick(2);
    int_req = 2'b00; rst = 1;
    #1;
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_rvalid", int_rvalid, 0);
    chk("mid_rst_ack", emif_ack, 0);
    chk("mid_rst_int_rdata", int_rdata, 0);
    chk("mid_rst_emif_rdata", emif_rdata, 0);
    tick(2);
    rst = 0;
    tick(1);
    c = cyc;
    int_req = 2'b10;
    exp_ram(0, 7'h11, 0, c + 1); exp_rsp(0, 2'b10, 2'b00, 0, 0, c + 1); exp_rsp(0, 2'b00, 2'b10, 16'h5555, 1, c + 3);
    tick(2);
    int_req = 2'b00;
    tick(3);
    host_op(0, 7'h3D, 16'h0, 16'h7777);
`ifdef EMIF_ARB_FAIRNESS_EN
    // host keeps requesting while req1 waits: req1 wins after four host grants
    c = cyc;
    int_req = 2'b10; int_we = 2'b10; int_addr = {7'h30, 7'h0}; int_wdata = {16'h0101, 16'h0};
    for (int i = 0; i < 4; i++) begin
      emif_req = 1; emif_we = 1; emif_addr = 7'(7'h40 + i); emif_wdata = 16'(i);
      exp_ram(1, 7'(7'h40 + i), 16'(i), c + 2 * i + 1); exp_rsp(1, 2'b00, 2'b00, 0, 0, c + 2 * i + 1);
      tick(1);
      emif_req = 0;
      tick(1);
    end
    emif_req = 1; emif_addr = 7'h44; emif_wdata = 16'h4;
    exp_ram(1, 7'h30, 16'h0101, c + 9); exp_rsp(0, 2'b10, 2'b00, 0, 0, c + 9);
    exp_ram(1, 7'h44, 16'h4, c + 11); exp_rsp(1, 2'b00, 2'b00, 0, 0, c + 11);
    tick(1);
    int_req = 2'b00; int_we = 2'b00;
    tick(2);
    emif_req = 0;
    tick(2);
    host_op(0, 7'h30, 16'h0, 16'h0101);
`endif
    tick(5);
    chk("ram_queue_empty", mq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/emif_ram_arbiter.md
Name: emif_ram_arbiter

Overview:
- Sequences all accesses to the single-port 16-bit register RAM shared by the EMIF slave front end and internal fabric requesters, such as the free-running counter updater and the speed-module readback/mirror logic.
- Host port has fixed priority and is stretched with a wait flag.
- Internal requesters are served round-robin.
- Sits between the EMIF decode logic and the RAM array, in the PLL c0 domain.

Parameters:
- ADDR_W, 7, RAM word address width (128 words)
- DATA_W, 16, RAM data width
- N_REQ, 2, number of internal requesters (1..8)
- HOST_STREAK, 4, consecutive host grants before a pending internal request is forced (used only with the optional feature)

Ports:
- clk  in  1  c0 domain clock
- rst  in  1  asynchronous, active-high reset
- emif_req  in  1  host access pending (level, synchronised by front end)
- emif_we  in  1  1 = write, 0 = read
- emif_addr  in  ADDR_W  host word address
- emif_wdata  in  DATA_W  host write data
- emif_rdata  out  DATA_W  host read data, held until next host read completes
- emif_ack  out  1  one-cycle completion pulse
- emif_wait  out  1  high while host request is accepted but not completed (front end maps to nWAIT polarity)
- int_req  in  N_REQ  internal request levels
- int_we  in  N_REQ  per-requester write flag
- int_addr  in  N_REQ*ADDR_W  packed addresses, requester 0 in LSBs
- int_wdata  in  N_REQ*DATA_W  packed write data
- int_gnt  out  N_REQ  one-hot pulse: request consumed, requester may change its inputs next cycle
- int_rvalid  out  N_REQ  one-hot pulse: int_rdata valid
- int_rdata  out  DATA_W  shared internal read data
- ram_en, ram_we  out  1  RAM strobes
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer 0, host rearm flag 1.
- Reset mid-transaction aborts it; no ack/gnt/rvalid is issued.
- State IDLE: arbitrate among eligible requests.
  - Host is eligible when emif_req=1 and rearm=1.
  - Host beats internal requests.
  - Internal winner is the first set int_req at or after the RR pointer, wrapping.
  - Winner's we/addr/wdata are registered. Go to ISSUE; stay in IDLE if nothing is eligible.
- State ISSUE, 1 cycle:
  - ram_en=1; ram_we, ram_addr and ram_wdata come from the latched winner.
  - Internal winner: int_gnt pulses.
  - Write: emif_ack pulses (host winner), then go to IDLE.
  - Read: go to CAPTURE.
- State CAPTURE: ram_rdata is registered into emif_rdata or int_rdata; go to RESP.
- State RESP: emif_ack or the winner's int_rvalid pulses; go to IDLE.
- Latency from the request seen in IDLE (cycle 0):
  - Write: completes in cycle 1.
  - Read: data and ack in cycle 3.
  - Maximum throughput: one write every 2 cycles, one read every 4 cycles.
- RR pointer: set to (winner+1) mod N_REQ on each internal grant. Unchanged on host grants.
- Rearm:
  - Cleared when emif_ack pulses.
  - Set again only after emif_req is sampled 0.
  - A level held high across the ack is never serviced twice.
- emif_wait = emif_req & rearm & ~emif_ack (combinational). Host sees wait drop in the ack cycle.
- Internal requests that drop before grant are ignored without error.
- Inputs change only while idle or after gnt; arbiter behaviour is undefined otherwise.
- int_rdata and emif_rdata are not cleared between reads.

Optional Feature:
- Macro EMIF_ARB_FAIRNESS_EN.
- Defined:
  - A counter tracks consecutive host grants while any int_req is pending.
  - When the counter reaches HOST_STREAK, the next arbitration goes to the RR internal winner; the counter then resets.
  - The counter resets on any internal grant or when no internal request is pending.
- Undefined: strict host priority; internal requesters may starve.

Decomposition:
- Package emif_pkg:
  - EMIF_ADDR_W and EMIF_DATA_W constants.
  - arb_state_t enum {IDLE, ISSUE, CAPTURE, RESP}.
  - src_t enum {SRC_HOST, SRC_INT}.
- Sub-module rr_arbiter:
  - Combinational one-hot round-robin picker plus registered pointer, parameterised on N_REQ.
  - Pointer update enabled by the grant strobe.

Test Plan:
- Host write addr 0x3C data 0x1234 → ISSUE cycle has ram_we=1, addr 0x3C; emif_ack in cycle 1. Host read of 0x3C → emif_rdata=0x1234 and ack in cycle 3.
- int_req=2'b11 held, both reads → grants alternate req0, req1, req0; int_rvalid one-hot matches each grant.
- Host and int_req[0] raised in the same cycle → host served first; req0 granted in the following arbitration (cycle 2 for a host write).
- emif_req held high for 10 cycles after ack → exactly one ram_en; emif_wait stays 0; a new access is served only after a 1-cycle low.
- rst asserted during CAPTURE → no ack/rvalid; all outputs 0 immediately; the next request is served normally.
- With EMIF_ARB_FAIRNESS_EN, HOST_STREAK=4, host continuously requesting plus int_req[1] pending → req1 granted after exactly 4 host grants.
